uart_rx_fifo: RTL

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

---
 rtl/uart_rx_fifo.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo
//
// Drains a UART receiver into a small first-word-fall-through FIFO.
// A four-state drain FSM watches rxrdy. When rxrdy is high and there is room,
// it pulses rx_read_n low for exactly one cycle and latches the received byte
// into the tail entry. It then waits for the receiver to drop rxrdy before it
// looks for the next byte, so the same byte is never captured twice.
// When the FIFO is full, the byte stays in the receiver.
//
// Optional feature macro: RXFIFO_ERRFLAGS_EN
//   defined   : each entry also stores parity/framing/overrun flags, and
//               dout_perr/dout_ferr/dout_ovr show the head entry's flags.
//   undefined : entries hold data only, the status inputs are ignored, and
//               the dout_* status outputs are tied low.
//
// Parameters
//   DEPTH      entry count, power of two in 2..64
//
// Ports
//   mclkx16    in   system clock (16x baud)
//   reset      in   asynchronous active-high reset
//   rxrdy      in   receiver has a byte ready
//   rdata      in   receiver data, valid while rx_read_n is low
//   parityerr  in   receiver parity error flag
//   framingerr in   receiver framing error flag
//   overrun    in   receiver overrun flag
//   rx_read_n  out  receiver read strobe, idle high, driven from a flop
//   pop        in   host dequeue request (ignored when empty)
//   dout       out  head entry data (fall-through, no latency)
//   dout_perr  out  head entry parity error flag
//   dout_ferr  out  head entry framing error flag
//   dout_ovr   out  head entry overrun flag
//   empty      out  count == 0
//   full       out  count == DEPTH
//   count      out  occupancy, 0..DEPTH
// ---------------------------------------------------------------------------
module uart_rx_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     mclkx16,
  input  logic                     reset,
  input  logic                     rxrdy,
  input  logic [7:0]               rdata,
  input  logic                     parityerr,
  input  logic                     framingerr,
  input  logic                     overrun,
  output logic                     rx_read_n,
  input  logic                     pop,
  output logic [7:0]               dout,
  output logic                     dout_perr,
  output logic                     dout_ferr,
  output logic                     dout_ovr,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

`ifdef RXFIFO_ERRFLAGS_EN
  localparam int ENTRY_W = 11;
`else
  localparam int ENTRY_W = 8;
`endif

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ASSERT   = 2'd1,
    RELEASE  = 2'd2,
    WAIT_CLR = 2'd3
  } state_t;

  state_t          state_reg, state_next;
  logic            rx_read_n_reg, rx_read_n_next;
  logic [AW-1:0]   wr_ptr_reg, wr_ptr_next;
  logic [AW-1:0]   rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0]   count_reg, count_next;

  logic            push;
  logic            do_pop;
  logic            full_int;
  logic            empty_int;

  // Storage has no reset. Only the pointers and the count say which entries
  // hold valid data.
  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [ENTRY_W-1:0] wr_entry;
  logic [ENTRY_W-1:0] head_entry;

  assign full_int  = (count_reg == CNT_FULL);
  assign empty_int = (count_reg == '0);

  // The capture happens at the edge that leaves ASSERT. The reset term keeps
  // a capture from landing if reset arrives while the strobe is low.
  assign push   = (state_reg == ASSERT) && !reset;
  assign do_pop = pop && !empty_int;

  // -------------------------------------------------------------------------
  // Drain FSM: next state and strobe
  // -------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE: begin
        if (rxrdy && !full_int) begin
          state_next = ASSERT;
        end
      end
      ASSERT: begin
        state_next = RELEASE;
      end
      RELEASE: begin
        state_next = WAIT_CLR;
      end
      WAIT_CLR: begin
        // The receiver may be slow to drop rxrdy after the rising strobe.
        // Holding here is what prevents a second capture of the same byte.
        if (!rxrdy) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    // The strobe is registered from the next state. rx_read_n is therefore
    // low exactly while the FSM sits in ASSERT, and it comes straight from
    // a flop.
    rx_read_n_next = (state_next != ASSERT);
  end

  // -------------------------------------------------------------------------
  // Pointer and occupancy next-state
  // -------------------------------------------------------------------------
  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;

    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    if (push) begin
      wr_ptr_next = wr_ptr_reg + PTR_ONE;
    end
    if (do_pop) begin
      rd_ptr_next = rd_ptr_reg + PTR_ONE;
    end

    unique case ({push, do_pop})
      2'b10:   count_next = count_reg + CNT_ONE;
      2'b01:   count_next = count_reg - CNT_ONE;
      default: count_next = count_reg;
    endcase
  end

  // -------------------------------------------------------------------------
  // Control registers (asynchronous reset)
  // -------------------------------------------------------------------------
  always_ff @(posedge mclkx16 or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      rx_read_n_reg <= 1'b1;
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
    end else begin
      state_reg     <= state_next;
      rx_read_n_reg <= rx_read_n_next;
      wr_ptr_reg    <= wr_ptr_next;
      rd_ptr_reg    <= rd_ptr_next;
      count_reg     <= count_next;
    end
  end

  // -------------------------------------------------------------------------
  // Entry packing and storage
  // -------------------------------------------------------------------------
`ifdef RXFIFO_ERRFLAGS_EN
  assign wr_entry = {overrun, framingerr, parityerr, rdata};
`else
  assign wr_entry = rdata;
  // The status inputs have no function in this build.
  logic status_unused;
  assign status_unused = &{1'b0, parityerr, framingerr, overrun};
`endif

  always_ff @(posedge mclkx16) begin
    if (push) begin
      mem[wr_ptr_reg] <= wr_entry;
    end
  end

  // Fall-through read: the head is presented straight from storage. While
  // the FIFO is empty, this shows stale contents at the read pointer.
  assign head_entry = mem[rd_ptr_reg];
  assign dout       = head_entry[7:0];

`ifdef RXFIFO_ERRFLAGS_EN
  assign dout_perr = head_entry[8];
  assign dout_ferr = head_entry[9];
  assign dout_ovr  = head_entry[10];
`else
  assign dout_perr = 1'b0;
  assign dout_ferr = 1'b0;
  assign dout_ovr  = 1'b0;
`endif

  assign rx_read_n = rx_read_n_reg;
  assign empty     = empty_int;
  assign full      = full_int;
  assign count     = count_reg;

endmodule
